// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: state encoding and default sizes shared by the mem_arbiter files
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arb_if: requester handshake plus RAM port bundle; slave is the arbiter view, master the requesters/RAM view
interface mem_arb_if import mem_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [NUM_REQ-1:0]        reqValid;
  logic [NUM_REQ-1:0]        reqWrite;
  logic [NUM_REQ*ADDR_W-1:0] reqAddr;
  logic [NUM_REQ*DATA_W-1:0] reqData;
  logic [NUM_REQ-1:0]        reqGrant;
  logic [NUM_REQ-1:0]        rspValid;
  logic [DATA_W-1:0]         rspData;
  logic [ADDR_W-1:0]         ramAddress;
  logic [DATA_W-1:0]         ramOut;
  logic                      readReq;
  logic                      writeReq;
  logic [DATA_W-1:0]         ramValue;
  modport slave (
    input  reqValid, reqWrite, reqAddr, reqData, ramValue,
    output reqGrant, rspValid, rspData, ramAddress, ramOut, readReq, writeReq
  );
  modport master (
    output reqValid, reqWrite, reqAddr, reqData, ramValue,
    input  reqGrant, rspValid, rspData, ramAddress, ramOut, readReq, writeReq
  );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: one-hot request selector scanning upward (with wrap) from a priority pointer
module rr_pick import mem_arb_pkg::*; #(
  parameter int N = DEF_NUM_REQ,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  int j;
  logic found;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = IW'(j);
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises requester accesses onto one registered-read RAM port, three cycles per access.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin priority; otherwise fixed priority, requester 0 highest.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic clk,
  input logic reset,
  mem_arb_if.slave bus
);
  localparam int IW = idx_w(NUM_REQ);
  state_t state_q;
  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] rsp_q;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] sel_data;
  logic sel_wr;
  logic rd_q;
  logic wr_q;
  logic is_wr_q;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i(bus.reqValid),
    .ptr_i(ptr),
    .gnt_o(pick),
    .idx_o(pick_idx)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  assign ptr_d = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
  assign ptr = ptr_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else if (state_q == IDLE && |bus.reqValid) ptr_q <= ptr_d;
  end
`else
  assign ptr = '0;
`endif

  assign sel_addr = bus.reqAddr[pick_idx*ADDR_W +: ADDR_W];
  assign sel_data = bus.reqData[pick_idx*DATA_W +: DATA_W];
  assign sel_wr = bus.reqWrite[pick_idx];

  // strobes and grant are registered on entry to ISSUE so they last exactly that cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= '0;
      rsp_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      is_wr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|bus.reqValid) begin
          state_q <= ISSUE;
          gnt_q <= pick;
          addr_q <= sel_addr;
          data_q <= sel_data;
          is_wr_q <= sel_wr;
          rd_q <= !sel_wr;
          wr_q <= sel_wr;
        end
        ISSUE: begin
          state_q <= RESP;
          gnt_q <= '0;
          rd_q <= 1'b0;
          wr_q <= 1'b0;
          rsp_q <= gnt_q;
        end
        default: begin
          state_q <= IDLE;
          rsp_q <= '0;
        end
      endcase
    end
  end

  assign bus.reqGrant = gnt_q;
  assign bus.rspValid = rsp_q;
  assign bus.ramAddress = addr_q;
  assign bus.ramOut = data_q;
  assign bus.readReq = rd_q;
  assign bus.writeReq = wr_q;
  assign bus.rspData = (state_q == RESP && !is_wr_q) ? bus.ramValue : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int N = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total = 0;
  int rr_next = 0;
  logic [DW-1:0] ram [256];
  logic ram_clr = 1'b0;
  logic pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic [DW-1:0] model_mem [logic [AW-1:0]];

  always #5 clk = ~clk;

  mem_arb_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // RAM with registered read; a poison value when not reading exposes ungated rspData
  always @(posedge clk) begin
    if (ram_clr) for (int k = 0; k < 256; k++) ram[k] <= '0;
    else if (pl_en) ram[pl_addr[9:2]] <= pl_data;
    else if (bus.writeReq) ram[bus.ramAddress[9:2]] <= bus.ramOut;
    bus.ramValue <= bus.readReq ? ram[bus.ramAddress[9:2]] : 32'hBAD0BAD0;
  end

  function automatic int model_pick(input logic [N-1:0] v);
    int s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    s = rr_next;
`else
    s = 0;
`endif
    for (int k = 0; k < N; k++) if (v[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.reqValid[i] = 1'b1;
    bus.reqWrite[i] = w;
    bus.reqAddr[i*AW +: AW] = a;
    bus.reqData[i*DW +: DW] = d;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.reqGrant == '0 && cyc < 12);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ram_clr = 1'b1;
    bus.reqValid = '0;
    repeat (2) @(negedge clk);
    ram_clr = 1'b0;
    total++;
    if ({bus.reqGrant, bus.rspValid, bus.readReq, bus.writeReq} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 0", {bus.reqGrant, bus.rspValid, bus.readReq, bus.writeReq});
    else passed++;
    total++;
    if ({bus.ramAddress, bus.ramOut, bus.rspData} !== 96'b0)
      $display("FAIL reset_data: addr %h out %h rsp %h want 0", bus.ramAddress, bus.ramOut, bus.rspData);
    else passed++;
    reset = 1'b0;
    rr_next = 0;
    preload(32'h10, 32'hA5A5A5A5);
    set_req(0, 1'b1, 32'h10, 32'h11111111);
    @(negedge clk);
    total++;
    if ({bus.writeReq, bus.reqGrant} !== {1'b1, 2'b01})
      $display("FAIL reset_pre_issue: got %b want 101", {bus.writeReq, bus.reqGrant});
    else passed++;
    #1 reset = 1'b1;
    #1;
    total++;
    if ({bus.reqGrant, bus.rspValid, bus.readReq, bus.writeReq} !== 6'b0)
      $display("FAIL reset_mid_issue_ctrl: got %b want 0", {bus.reqGrant, bus.rspValid, bus.readReq, bus.writeReq});
    else passed++;
    total++;
    if ({bus.ramAddress, bus.ramOut, bus.rspData} !== 96'b0)
      $display("FAIL reset_mid_issue_data: addr %h out %h rsp %h want 0", bus.ramAddress, bus.ramOut, bus.rspData);
    else passed++;
    bus.reqValid = '0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({bus.readReq, bus.writeReq, bus.reqGrant, bus.rspValid} !== 6'b0)
        $display("FAIL reset_hold: got %b want 0", {bus.readReq, bus.writeReq, bus.reqGrant, bus.rspValid});
      else passed++;
    end
    total++;
    if (ram[4] !== 32'hA5A5A5A5) $display("FAIL reset_ram: got %h want a5a5a5a5", ram[4]);
    else passed++;
    reset = 1'b0;
    rr_next = 0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    preload(32'h04, 32'hDEADBEEF);
    set_req(0, 1'b0, 32'h04, 32'h0);
    @(negedge clk);
    total++;
    if ({bus.readReq, bus.writeReq, bus.reqGrant} !== {1'b1, 1'b0, 2'b01})
      $display("FAIL read_issue: got %b want 1001", {bus.readReq, bus.writeReq, bus.reqGrant});
    else passed++;
    total++;
    if (bus.ramAddress !== 32'h04) $display("FAIL read_addr: got %h want 4", bus.ramAddress);
    else passed++;
    rr_next = 1;
    bus.reqValid[0] = 1'b0;
    @(negedge clk);
    total++;
    if (bus.rspValid !== 2'b01) $display("FAIL read_rspvalid: got %b want 01", bus.rspValid);
    else passed++;
    total++;
    if (bus.rspData !== 32'hDEADBEEF) $display("FAIL read_rspdata: got %h want deadbeef", bus.rspData);
    else passed++;
    total++;
    if ({bus.readReq, bus.writeReq} !== 2'b00) $display("FAIL read_strobe_len: got %b want 00", {bus.readReq, bus.writeReq});
    else passed++;
    @(negedge clk);
    total++;
    if (bus.rspValid !== 2'b00) $display("FAIL read_rsp_len: got %b want 00", bus.rspValid);
    else passed++;
  endtask

  task automatic test_write_read();
    set_req(1, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    total++;
    if ({bus.readReq, bus.writeReq, bus.reqGrant} !== {1'b0, 1'b1, 2'b10})
      $display("FAIL write_issue: got %b want 0110", {bus.readReq, bus.writeReq, bus.reqGrant});
    else passed++;
    total++;
    if ({bus.ramAddress, bus.ramOut} !== {32'h20, 32'h12345678})
      $display("FAIL write_bus: addr %h data %h want 20 12345678", bus.ramAddress, bus.ramOut);
    else passed++;
    rr_next = 0;
    bus.reqValid[1] = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.rspValid, bus.rspData} !== {2'b10, 32'h0})
      $display("FAIL write_rsp: valid %b data %h want 10 0", bus.rspValid, bus.rspData);
    else passed++;
    @(negedge clk);
    set_req(1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    total++;
    if ({bus.readReq, bus.writeReq, bus.reqGrant} !== {1'b1, 1'b0, 2'b10})
      $display("FAIL readback_issue: got %b want 1010", {bus.readReq, bus.writeReq, bus.reqGrant});
    else passed++;
    rr_next = 0;
    bus.reqValid[1] = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.rspValid, bus.rspData} !== {2'b10, 32'h12345678})
      $display("FAIL readback_rsp: valid %b data %h want 10 12345678", bus.rspValid, bus.rspData);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int cyc;
    int win;
    logic [N-1:0] exp_g;
    set_req(0, 1'b0, 32'h40, 32'h0);
    set_req(1, 1'b0, 32'h44, 32'h0);
    for (int a = 0; a < 4; a++) begin
      wait_grant(cyc);
      win = model_pick(bus.reqValid);
      exp_g = '0;
      exp_g[win] = 1'b1;
      total++;
      if (bus.reqGrant !== exp_g) $display("FAIL contention_grant%0d: got %b want %b", a, bus.reqGrant, exp_g);
      else passed++;
      if (a > 0) begin
        total++;
        if (cyc !== 3) $display("FAIL contention_gap%0d: got %0d want 3", a, cyc);
        else passed++;
      end
      rr_next = (win + 1) % N;
    end
    bus.reqValid[0] = 1'b0;
    wait_grant(cyc);
    total++;
    if (bus.reqGrant !== 2'b10) $display("FAIL contention_drop: got %b want 10", bus.reqGrant);
    else passed++;
    total++;
    if (cyc !== 3) $display("FAIL contention_drop_gap: got %0d want 3", cyc);
    else passed++;
    rr_next = 0;
    bus.reqValid = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random(input int n_acc);
    logic [N-1:0] pend;
    logic [N-1:0] drv_prev;
    logic [N-1:0] exp_g;
    logic [N-1:0] exp_rsp;
    logic [AW-1:0] p_addr [N];
    logic [DW-1:0] p_data [N];
    logic p_wr [N];
    logic [DW-1:0] exp_data;
    int since;
    int issued;
    int done;
    int win;
    int cyc;
    pend = '0;
    drv_prev = '0;
    exp_rsp = '0;
    exp_data = '0;
    since = 99;
    issued = 0;
    done = 0;
    cyc = 0;
    while (done < n_acc && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      since++;
      total++;
      if (bus.readReq && bus.writeReq) $display("FAIL rand_strobe_excl: both strobes high cycle %0d", cyc);
      else passed++;
      total++;
      if (!$onehot0(bus.reqGrant) || !$onehot0(bus.rspValid))
        $display("FAIL rand_onehot: grant %b rsp %b", bus.reqGrant, bus.rspValid);
      else passed++;
      total++;
      if (bus.rspValid !== exp_rsp || (exp_rsp != '0 && bus.rspData !== exp_data))
        $display("FAIL rand_rsp: valid %b data %h want %b %h", bus.rspValid, bus.rspData, exp_rsp, exp_data);
      else passed++;
      exp_rsp = '0;
      // the arbiter can only accept again once three cycles have passed since its last grant
      win = (since >= 3 && drv_prev != '0) ? model_pick(drv_prev) : -1;
      exp_g = '0;
      if (win >= 0) exp_g[win] = 1'b1;
      total++;
      if (bus.reqGrant !== exp_g) $display("FAIL rand_grant: got %b want %b cycle %0d", bus.reqGrant, exp_g, cyc);
      else passed++;
      if (win >= 0) begin
        total++;
        if ({bus.readReq, bus.writeReq} !== {!p_wr[win], p_wr[win]} || bus.ramAddress !== p_addr[win] ||
            (p_wr[win] && bus.ramOut !== p_data[win]))
          $display("FAIL rand_strobe: rd %b wr %b addr %h out %h want wr %b addr %h out %h",
                   bus.readReq, bus.writeReq, bus.ramAddress, bus.ramOut, p_wr[win], p_addr[win], p_data[win]);
        else passed++;
        exp_rsp = exp_g;
        exp_data = p_wr[win] ? '0 : (model_mem.exists(p_addr[win]) ? model_mem[p_addr[win]] : '0);
        if (p_wr[win]) model_mem[p_addr[win]] = p_data[win];
        pend[win] = 1'b0;
        since = 0;
        rr_next = (win + 1) % N;
        done++;
      end else begin
        total++;
        if ({bus.readReq, bus.writeReq} !== 2'b00) $display("FAIL rand_idle_strobe: got %b want 00", {bus.readReq, bus.writeReq});
        else passed++;
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && issued < n_acc && $urandom_range(1, 0) == 1) begin
          pend[i] = 1'b1;
          issued++;
          p_wr[i] = 1'($urandom_range(1, 0));
          p_addr[i] = 32'h100 + 32'($urandom_range(15, 0)) * 4;
          p_data[i] = $urandom;
          set_req(i, p_wr[i], p_addr[i], p_data[i]);
        end
        bus.reqValid[i] = pend[i];
      end
      drv_prev = bus.reqValid;
    end
    total++;
    if (done !== n_acc) $display("FAIL rand_timeout: completed %0d want %0d", done, n_acc);
    else passed++;
    bus.reqValid = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.reqValid = '0;
    bus.reqWrite = '0;
    bus.reqAddr = '0;
    bus.reqData = '0;
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_random(1000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
